gsim_enc: RTL
=============

GSIM_ENC -- requirements
Module: gsim_enc

Interface
REQ-001 Parameter ROUND_EN, default 1, meaning: 1 = round-half-up to integer, 0 = truncate (floor).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_en  input  1  x_in valid this cycle; sampled only in RECEIVE.
REQ-005 x_in  input  32  signed Q16.16 solution element, x0 first, x15 last.
REQ-006 out_valid  output  1  b_out valid this cycle.
REQ-007 b_out  output  16  signed integer right-hand-side element, b0 first, b15 last.

Function
REQ-008 The block SHALL compute b = A*x for the fixed 16x16 banded matrix: diagonal 20, distance-1 -13, distance-2 +6, distance-3 -1; all other entries zero.
REQ-009 Neighbours with index <0 or >15 SHALL contribute zero.
REQ-010 FSM states SHALL be RECEIVE, CALC, SEND; reset state RECEIVE.
REQ-011 RECEIVE: each cycle with in_en=1 stores x_in at index cnt and increments cnt; in_en=0 cycles stall without loss; the 16th accepted word moves to CALC with cnt=0.
REQ-012 in_en SHALL be ignored in CALC and SEND.
REQ-013 CALC SHALL last exactly 18 cycles: one row issued per cycle (rows 0..15) into a 2-stage pipeline, plus 2 drain cycles; results stored in a 16-entry b register array.
REQ-014 Constant multiplies SHALL use shift-add only: 20x=(x<<4)+(x<<2), 13x=(x<<3)+(x<<2)+x, 6x=(x<<2)+(x<<1); no multipliers or dividers.
REQ-015 Pipeline stage 1 SHALL form symmetric pair sums (x[i-1]+x[i+1], x[i-2]+x[i+2], x[i-3]+x[i+3]) and weighted terms; stage 2 SHALL sum them with the diagonal term.
REQ-016 Accumulation SHALL be signed, 40 bits wide, with no intermediate overflow for any 32-bit input.
REQ-017 Conversion: ROUND_EN=1 -> floor(v + 0.5) (add 0x8000, arithmetic shift right 16); ROUND_EN=0 -> arithmetic shift right 16.
REQ-018 Converted result SHALL saturate to [-32768, 32767].
REQ-019 SEND SHALL assert out_valid for exactly 16 consecutive cycles, presenting b0..b15 in order, then return to RECEIVE with cnt=0.
REQ-020 Latency: if the 16th x is accepted on edge T, out_valid SHALL first be high in the cycle after edge T+19 (18 CALC cycles, then SEND).
REQ-021 b_out SHALL hold its last value when out_valid=0.
REQ-022 A new frame MAY begin the cycle after the final SEND cycle; back-to-back frames SHALL need no idle cycle.

Reset
REQ-023 reset low SHALL asynchronously force state=RECEIVE, cnt=0, out_valid=0, b_out=0, and clear the pipeline registers.
REQ-024 reset mid-RECEIVE, CALC or SEND SHALL discard the frame; the next 16 accepted words form a new frame.
REQ-025 x and b storage arrays need no reset.

Structure
REQ-026 Shared package gsim_pkg SHALL hold N_VAR=16, coefficient constants (20, 13, 6, 1), Q-format widths (32 total, 16 fractional), and the state enum; the Gauss-Seidel solver SHALL use the same package.
REQ-027 The row arithmetic SHALL live in one sub-module, banded_row_mac (7 taps in, 40-bit sum out, 2-cycle latency).

Verification
REQ-028 All x=1.0 (0x00010000) -> b = 12,-1,5,4,4,4,4,4,4,4,4,4,4,5,-1,12.
REQ-029 x5=1.0, others 0 -> b2=-1, b3=6, b4=-13, b5=20, b6=-13, b7=6, b8=-1, all others 0.
REQ-030 x0=0.5 (0x00008000), others 0, ROUND_EN=1 -> b0=10, b1=-6, b2=3, b3=0, rest 0; ROUND_EN=0 -> b1=-7, b3=-1.
REQ-031 Alternating x=+2000.0/-2000.0 -> interior rows saturate to 32767 (even i) or -32768 (odd i).
REQ-032 in_en gaps in RECEIVE plus in_en=1 pulses during CALC/SEND -> results identical to a gap-free frame; out_valid exactly 16 cycles; first out_valid cycle per REQ-020.
REQ-033 reset pulsed during CALC -> out_valid stays 0; the following frame with all x=1.0 returns the REQ-028 values.

Source files
------------

// File: rtl/gsim_pkg.sv
// rtl/gsim_pkg.sv - shared constants, state type and fixed-point helper for the Gauss-Seidel encoder/solver
//
// Purpose : common definitions for gsim_enc (b = A*x encoder) and the
//           Gauss-Seidel solver that works on the same banded system.
// Contents: problem size, band coefficients, Q16.16 widths, accumulator
//           width, FSM state enum, Q16.16 -> saturated int16 conversion.
package gsim_pkg;

   localparam int N_VAR       = 16;
   localparam int IDX_W       = 4;              // index into x/b arrays
   localparam int CNT_W       = 5;              // counts up to CALC_CYCLES-1
   localparam int CALC_CYCLES = N_VAR + 2;      // 16 issue cycles + 2 drain
   localparam int N_TAPS      = 7;              // x[i-3] .. x[i+3]

   // Band of A: diagonal, then distance 1, 2, 3 (signs -, +, - applied in the MAC)
   localparam int COEF_D = 20;
   localparam int COEF_1 = 13;
   localparam int COEF_2 = 6;
   localparam int COEF_3 = 1;

   localparam int Q_W    = 32;
   localparam int Q_FRAC = 16;
   localparam int ACC_W  = 40;   // sum of |coef| = 60 < 2^6, so 32+6 bits plus margin
   localparam int B_W    = 16;

   typedef enum logic [1:0] {
      ST_RECEIVE = 2'd0,
      ST_CALC    = 2'd1,
      ST_SEND    = 2'd2
   } gsim_state_e;

   localparam logic signed [ACC_W-1:0] HALF_LSB = 40'sh00_0000_8000;
   localparam logic signed [ACC_W-1:0] B_MAX    = 40'sd32767;
   localparam logic signed [ACC_W-1:0] B_MIN    = -40'sd32768;

   // Q16.16 accumulator -> integer, rounding half up (floor(v+0.5)) or
   // flooring, then clamped to the int16 range.
   function automatic logic signed [B_W-1:0] q_to_int_sat(
      input logic signed [ACC_W-1:0] v,
      input logic                    round_en
   );
      logic signed [ACC_W-1:0] biased;
      logic signed [ACC_W-1:0] shifted;
      logic signed [B_W-1:0]   res;
      biased  = round_en ? (v + HALF_LSB) : v;
      shifted = biased >>> Q_FRAC;
      if (shifted > B_MAX) begin
         res = 16'sh7FFF;
      end else if (shifted < B_MIN) begin
         res = 16'sh8000;
      end else begin
         res = shifted[B_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/banded_row_mac.sv
// rtl/banded_row_mac.sv - two-stage shift-add MAC for one row of the banded matrix
//
// Purpose : sum_o = 20*x[i] - 13*(x[i-1]+x[i+1]) + 6*(x[i-2]+x[i+2])
//                   - (x[i-3]+x[i+3]), two cycles after valid_i.
// Ports   : clk, reset (async active-low)
//           valid_i  - taps_i hold a row this cycle
//           taps_i   - taps_i[k] = x[i+k-3], out-of-range neighbours as zero
//           valid_o  - sum_o holds the row issued two cycles earlier
//           sum_o    - signed 40-bit Q16.16 row sum
module banded_row_mac
   import gsim_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           valid_i,
   input  logic [N_TAPS-1:0][Q_W-1:0]     taps_i,
   output logic                           valid_o,
   output logic signed [ACC_W-1:0]        sum_o
);

   // The shift-add network below is hard-wired for this band.
   if (COEF_D != 20 || COEF_1 != 13 || COEF_2 != 6 || COEF_3 != 1) begin : g_coef_check
      $error("banded_row_mac: shift-add network assumes coefficients 20/13/6/1");
   end

   logic signed [ACC_W-1:0] tap_e [N_TAPS];
   logic signed [ACC_W-1:0] pair1, pair2, pair3;
   logic signed [ACC_W-1:0] diag_d, w1_d, w2_d, w3_d;
   logic signed [ACC_W-1:0] diag_q, w1_q, w2_q, w3_q;
   logic signed [ACC_W-1:0] sum_d, sum_q;
   logic                    v1_q, v2_q;

   // Stage 1: sign-extend, symmetric pair sums and weighted terms.
   always_comb begin
      for (int k = 0; k < N_TAPS; k++) begin
         tap_e[k] = {{(ACC_W-Q_W){taps_i[k][Q_W-1]}}, taps_i[k]};
      end
      pair1  = tap_e[2] + tap_e[4];
      pair2  = tap_e[1] + tap_e[5];
      pair3  = tap_e[0] + tap_e[6];
      diag_d = (tap_e[3] <<< 4) + (tap_e[3] <<< 2);
      w1_d   = (pair1 <<< 3) + (pair1 <<< 2) + pair1;
      w2_d   = (pair2 <<< 2) + (pair2 <<< 1);
      w3_d   = pair3;
   end

   // Stage 2: combine with the band signs.
   always_comb begin
      sum_d = diag_q - w1_q + w2_q - w3_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         diag_q <= '0;
         w1_q   <= '0;
         w2_q   <= '0;
         w3_q   <= '0;
         sum_q  <= '0;
      end else begin
         v1_q   <= valid_i;
         diag_q <= diag_d;
         w1_q   <= w1_d;
         w2_q   <= w2_d;
         w3_q   <= w3_d;
         v2_q   <= v1_q;
         sum_q  <= sum_d;
      end
   end

   assign valid_o = v2_q;
   assign sum_o   = sum_q;

endmodule

// File: rtl/gsim_enc.sv
// rtl/gsim_enc.sv - b = A*x encoder for the fixed 16x16 banded Gauss-Seidel system
//
// Purpose : collects 16 Q16.16 x elements, computes the 16 rows of A*x
//           through banded_row_mac, converts each to a saturated int16
//           and streams b0..b15 out on 16 consecutive cycles.
// Params  : ROUND_EN - 1 round half up, 0 floor
// Ports   : clk, reset (async active-low)
//           in_en, x_in   - input word strobe and Q16.16 data (x0 first)
//           out_valid     - b_out valid this cycle
//           b_out         - int16 result (b0 first), held while out_valid=0
module gsim_enc
   import gsim_pkg::*;
#(
   parameter int ROUND_EN = 1
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_en,
   input  logic signed [Q_W-1:0] x_in,
   output logic                  out_valid,
   output logic signed [B_W-1:0] b_out
);

   gsim_state_e               state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      out_valid_q, out_valid_d;
   logic signed [B_W-1:0]     b_out_q, b_out_d;

   logic signed [Q_W-1:0]     x_q [N_VAR];
   logic signed [B_W-1:0]     b_q [N_VAR];

   logic                      x_we;
   logic                      issue;
   logic [N_TAPS-1:0][Q_W-1:0] taps;
   logic                      mac_valid;
   logic signed [ACC_W-1:0]   mac_sum;
   logic [IDX_W-1:0]          b_wr_idx;

   // FSM next state and output register inputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      b_out_d     = b_out_q;
      x_we        = 1'b0;
      issue       = 1'b0;
      case (state_q)
         ST_RECEIVE: begin
            if (in_en) begin
               x_we = 1'b1;
               if (cnt_q == CNT_W'(N_VAR-1)) begin
                  state_d = ST_CALC;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_CALC: begin
            issue = (cnt_q < CNT_W'(N_VAR));
            if (cnt_q == CNT_W'(CALC_CYCLES-1)) begin
               state_d = ST_SEND;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SEND: begin
            out_valid_d = 1'b1;
            b_out_d     = b_q[cnt_q[IDX_W-1:0]];
            if (cnt_q == CNT_W'(N_VAR-1)) begin
               state_d = ST_RECEIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RECEIVE;
            cnt_d   = '0;
         end
      endcase
   end

   // Seven-tap window around row cnt_q; the wrap of negative indices in
   // the unsigned sum lands above N_VAR, so one compare covers both edges.
   always_comb begin
      logic [CNT_W+1:0] idx;
      taps = '0;
      for (int t = 0; t < N_TAPS; t++) begin
         idx = {2'b00, cnt_q} + (CNT_W+2)'(t) - (CNT_W+2)'(3);
         if (idx < (CNT_W+2)'(N_VAR)) begin
            taps[t] = x_q[idx[IDX_W-1:0]];
         end
      end
   end

   banded_row_mac u_mac (
      .clk     (clk),
      .reset   (reset),
      .valid_i (issue),
      .taps_i  (taps),
      .valid_o (mac_valid),
      .sum_o   (mac_sum)
   );

   // The MAC answers two cycles after issue, so the row is cnt_q - 2.
   assign b_wr_idx = cnt_q[IDX_W-1:0] - IDX_W'(2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RECEIVE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         b_out_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         b_out_q     <= b_out_d;
      end
   end

   // Data arrays carry no reset; a frame always overwrites every entry.
   always_ff @(posedge clk) begin
      if (x_we) begin
         x_q[cnt_q[IDX_W-1:0]] <= x_in;
      end
      if (mac_valid) begin
         b_q[b_wr_idx] <= q_to_int_sat(mac_sum, ROUND_EN != 0);
      end
   end

   assign out_valid = out_valid_q;
   assign b_out     = b_out_q;

endmodule
